iqmap_bpsk: RTL and testbench

- BPSK symbol mapper; the transmit-side counterpart of the BPSK demapper in the comm datapath.
- Accepts 128-bit words via valid/ready and serializes each word MSB-first into signed 11-bit I/Q symbols, one symbol per ce slot.
- Inserts an idle gap after every 128-symbol frame so the downstream demapper can emit its word and re-arm.
- Holds a 1-deep word buffer so the next word can be accepted while the current frame transmits.

---
 rtl/iq_pkg.sv | 16 +
 rtl/bpsk_word_buf.sv | 30 +++
 rtl/iqmap_bpsk.sv | 95 +++++++++
 tb/tb_iqmap_bpsk.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared types and constants for the BPSK I/Q mapper.
package iq_pkg;
  localparam int SYM_W      = 11;
  localparam int FRAME_BITS = 128;
  localparam int AMP_DEF    = 256;

  typedef enum logic [1:0] {IDLE, DATA, GAP} state_t;

  localparam logic signed [SYM_W-1:0] POS_SYM = SYM_W'(AMP_DEF);
  localparam logic signed [SYM_W-1:0] NEG_SYM = SYM_W'(-AMP_DEF);

  // Bit 1 maps to +amp, bit 0 to -amp; amp is kept within 1..1023 so no saturation.
  function automatic logic signed [SYM_W-1:0] bpsk_sym(input logic b, input int amp);
    return b ? SYM_W'(amp) : SYM_W'(-amp);
  endfunction
endpackage

// File: rtl/bpsk_word_buf.sv
// One-deep word holding register: accepts on valid_i && ready_o, empties on pop.
module bpsk_word_buf #(
  parameter int W = 128
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         pop,
  output logic         ready_o,
  output logic         full,
  output logic [W-1:0] data
);
  // ready_o is its own register so the handshake output has no logic after the flop.
  // A pop and an accept never coincide: pop needs full, accept needs !full.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      full    <= 1'b0;
      ready_o <= 1'b1;
      data    <= '0;
    end else if (pop) begin
      full    <= 1'b0;
      ready_o <= 1'b1;
    end else if (valid_i && ready_o) begin
      full    <= 1'b1;
      ready_o <= 1'b0;
      data    <= data_i;
    end
  end
endmodule

// File: rtl/iqmap_bpsk.sv
// BPSK mapper: serializes buffered 128-bit words MSB-first into I symbols, one per ce slot.
module iqmap_bpsk
  import iq_pkg::*;
#(
  parameter int AMP        = 256,
  parameter int FRAME_BITS = 128,
  parameter int GAP_LEN    = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ce,
  input  logic                    valid_i,
  input  logic [FRAME_BITS-1:0]   data_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic signed [SYM_W-1:0] ar,
  output logic signed [SYM_W-1:0] ai,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int GW = $clog2(GAP_LEN + 1);

  state_t                state;
  logic [FRAME_BITS-1:0] sreg;
  logic [FRAME_BITS-1:0] buf_data;
  logic                  buf_full;
  logic                  pop;
  logic [7:0]            sym_cnt;
  logic [GW-1:0]         gap_cnt;

  assign pop  = ce && (state == IDLE) && buf_full;
  assign busy = (state != IDLE) || buf_full;
  assign ai   = '0;

  bpsk_word_buf #(.W(FRAME_BITS)) u_buf (
    .CLK     (CLK),
    .RST     (RST),
    .valid_i (valid_i),
    .data_i  (data_i),
    .pop     (pop),
    .ready_o (ready_o),
    .full    (buf_full),
    .data    (buf_data)
  );

  // sreg holds the bits not yet sent, next bit always at the MSB.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      sreg       <= '0;
      sym_cnt    <= '0;
      gap_cnt    <= '0;
      valid_o    <= 1'b0;
      ar         <= '0;
      frame_done <= 1'b0;
    end else if (!ce) begin
      valid_o    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (buf_full) begin
            sreg    <= {buf_data[FRAME_BITS-2:0], 1'b0};
            ar      <= bpsk_sym(buf_data[FRAME_BITS-1], AMP);
            valid_o <= 1'b1;
            sym_cnt <= 8'd1;
            state   <= DATA;
          end else begin
            valid_o <= 1'b0;
            ar      <= '0;
          end
        end
        DATA: begin
          sreg    <= {sreg[FRAME_BITS-2:0], 1'b0};
          ar      <= bpsk_sym(sreg[FRAME_BITS-1], AMP);
          valid_o <= 1'b1;
          sym_cnt <= sym_cnt + 8'd1;
          if (sym_cnt == 8'(FRAME_BITS - 1)) begin
            frame_done <= 1'b1;
            gap_cnt    <= '0;
            state      <= GAP;
          end
        end
        GAP: begin
          valid_o <= 1'b0;
          ar      <= '0;
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(GAP_LEN - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iqmap_bpsk.sv
// Scoreboard bench for iqmap_bpsk: accepted words expand into expected symbol/word queues.
module tb_iqmap_bpsk;
  localparam int AMP = 256;
  localparam int FB  = 128;
  localparam int GAP = 2;

  logic CLK = 1'b0, RST = 1'b0, ce = 1'b1, valid_i = 1'b0;
  logic [127:0] data_i = '0;
  logic ready_o, valid_o, busy, frame_done;
  logic signed [10:0] ar, ai;

  iqmap_bpsk #(.AMP(AMP), .FRAME_BITS(FB), .GAP_LEN(GAP)) dut (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .ar(ar), .ai(ai),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic signed [10:0] ar; bit last; } sym_t;
  sym_t         sym_q[$];
  logic [127:0] word_q[$];

  int tests = 0, fails = 0;
  int cyc = 0, acc_cnt = 0, done_cnt = 0, total_syms = 0;
  int last_done = -1000, last_gap = 0, nsym = 0;
  logic ce_e = 1'b1;
  bit in_frame = 0;
  logic signed [10:0] last_ar = '0;
  logic signed [10:0] p_sym = AMP, n_sym = -AMP;
  int ce_mode = 0, ph = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++; fails++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Reference: each accepted word becomes 128 symbols, MSB first, sign = bit value.
  initial forever begin
    @(posedge CLK);
    cyc++;
    ce_e = ce;
    if (!RST) begin
      sym_q.delete(); word_q.delete(); in_frame = 0; nsym = 0;
    end else if (valid_i && ready_o) begin
      acc_cnt++;
      word_q.push_back(data_i);
      for (int i = 0; i < FB; i++)
        sym_q.push_back('{data_i[FB-1-i] ? p_sym : n_sym, i == FB-1});
    end
  end

  // Monitor: pops one expected symbol per valid_o and rebuilds words like a demapper would.
  initial begin
    sym_t s;
    logic [127:0] asm_w = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (valid_o) begin
          check("valid_after_ce", ce_e, 1'b1);
          if (sym_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_symbol: got ar=%0d expected no symbol", ar);
          end else begin
            s = sym_q.pop_front();
            check("sym_ar", ar, s.ar);
            check("sym_ai", ai, 128'd0);
            check("frame_done", frame_done, s.last);
            if (!in_frame) begin last_gap = cyc - last_done; in_frame = 1; nsym = 0; end
            asm_w = {asm_w[126:0], ar > 0};
            nsym++; total_syms++; last_ar = ar;
            if (s.last) begin
              in_frame = 0; last_done = cyc; done_cnt++;
              check("frame_len", nsym, FB);
              if (word_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL loop_word: got %0h expected no word", asm_w);
              end else check("loop_word", asm_w, word_q.pop_front());
            end
          end
        end else begin
          check("done_no_valid", frame_done, 1'b0);
          if (in_frame) begin
            if (ce_e) check("frame_bubble", valid_o, 1'b1);
            else      check("ar_hold", ar, last_ar);
          end
        end
      end
    end
  end

  // ce: every cycle, or one cycle in three in sparse mode.
  initial forever begin
    @(posedge CLK); #1;
    if (ce_mode == 0) ce = 1'b1;
    else begin ce = (ph == 0); ph = (ph + 1) % 3; end
  end

  task automatic send(input logic [127:0] w);
    int n = 0;
    valid_i = 1'b1; data_i = w;
    do begin @(posedge CLK); n++; end while (!ready_o && n < 5000);
    if (n >= 5000) timeout("send");
    #1 valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sym_q.size() != 0 || busy) && n < 20000) begin @(negedge CLK); n++; end
    if (n >= 20000) timeout("drain");
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    int n, base, d0, a0;
    logic [127:0] w;
    // 1: reset values
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_ar", ar, 128'd0);
    check("rst_ai", ai, 128'd0);
    check("rst_ready_o", ready_o, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);

    // 2: single frame, latency and trailing gap
    send(128'h8000_0000_0000_0000_0000_0000_0000_0001);
    @(negedge CLK); check("lat_t1_valid", valid_o, 1'b0);
    @(negedge CLK); check("lat_t2_valid", valid_o, 1'b1);
    n = 0;
    while (!frame_done && n < 500) begin @(negedge CLK); n++; end
    if (n >= 500) timeout("frame_done");
    for (int i = 0; i < GAP + 1; i++) begin
      @(negedge CLK);
      check("gap_valid", valid_o, 1'b0);
      check("gap_ar", ar, 128'd0);
    end
    wait_drain();

    // 3: back-to-back, second word waits for the first load
    a0 = acc_cnt;
    send({128{1'b1}});
    @(negedge CLK);
    check("b2b_ready_low", ready_o, 1'b0);
    check("b2b_busy", busy, 1'b1);
    send('0);
    wait_drain();
    check("b2b_accepts", acc_cnt - a0, 2);
    check("b2b_gap", last_gap, GAP + 1);

    // 4: sparse ce
    ce_mode = 1;
    d0 = done_cnt;
    send({4{32'hAAAA_AAAA}});
    wait_drain();
    ce_mode = 0;
    check("sparse_frames", done_cnt - d0, 1);

    // 5: reset mid-frame drops the frame and the buffered word
    d0 = done_cnt;
    send({$urandom, $urandom, $urandom, $urandom});
    send({$urandom, $urandom, $urandom, $urandom});
    base = total_syms; n = 0;
    while (total_syms < base + 50 && n < 5000) begin @(negedge CLK); n++; end
    if (n >= 5000) timeout("mid_frame");
    RST = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_valid_o", valid_o, 1'b0);
    check("mid_rst_ar", ar, 128'd0);
    check("mid_rst_ready_o", ready_o, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    repeat (300) @(negedge CLK);
    check("mid_rst_no_done", done_cnt - d0, 0);

    // 6: random words, reassembled from the symbol stream
    d0 = done_cnt;
    for (int k = 0; k < 20; k++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      send(w);
    end
    wait_drain();
    check("loop_frames", done_cnt - d0, 20);
    check("loop_queue_empty", word_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
